// File: rtl/als153_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : als153_pkg
//  Description : Shared types, sizes and the rotate-priority pick function
//                for the SN54ALS153 round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package als153_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GRANT = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Returns {found, idx}. The search order is ptr+1, ptr+2, ... modulo NREQ.
  // The loop walks from the farthest candidate to the nearest one, so the
  // last hit, which is the nearest, wins.
  function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0]  req,
                                              input logic [SEL_W-1:0] ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/als153_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : als153_rr_pick
//  Description : Combinational rotate-priority encoder. The candidate after
//                ptr has the highest priority.
//  Revision    : 1.0  initial release
// ============================================================================
module als153_rr_pick
  import als153_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  assign {found, idx} = rr_pick(req, ptr);

endmodule
`default_nettype wire

// File: rtl/als153_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : als153_rr_arbiter
//  Description : Round-robin arbiter that shares one SN54ALS153 dual 4:1 mux
//                among four requesters. It drives the shared selects (A,B)
//                and the active-low section enables. The sequence is
//                break-before-make: SETUP -> GRANT -> GAP.
//  Revision    : 1.0  initial release
// ============================================================================
module als153_rr_arbiter
  import als153_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
)(
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic [NREQ-1:0] in_req,
  input  logic [1:0]      in_ch_en,
  output logic            out_A,
  output logic            out_B,
  output logic            out_G1_n,
  output logic            out_G2_n,
  output logic [NREQ-1:0] out_gnt,
  output logic            out_busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES);

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        ch_en_q;

  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  sel;
  logic [NREQ-1:0]   cur_mask;
  logic              rel_req;
  logic              forced_rot;

  // The select registers double as the record of the current winner.
  assign sel        = {out_A, out_B};
  assign cur_mask   = NREQ'(1) << sel;
  assign rel_req    = ~in_req[sel];
  assign forced_rot = (hold == HOLD_LIMIT) && (|(in_req & ~cur_mask));

  als153_rr_pick u_pick (
    .req   (in_req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Arbitration FSM. Every output is registered here. The selects move only
  // on IDLE/GAP -> SETUP edges, when both enables are high on both sides.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      hold     <= '0;
      gap_cnt  <= '0;
      ch_en_q  <= 2'b00;
      out_A    <= 1'b0;
      out_B    <= 1'b0;
      out_G1_n <= 1'b1;
      out_G2_n <= 1'b1;
      out_gnt  <= '0;
      out_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            {out_A, out_B} <= pick_idx;
            ch_en_q        <= in_ch_en;
            out_busy       <= 1'b1;
            state          <= SETUP;
          end
        end

        SETUP: begin
          // Enable sampling was frozen at arbitration. A request dropped
          // here still gets one grant cycle.
          out_gnt  <= cur_mask;
          out_G1_n <= ~ch_en_q[0];
          out_G2_n <= ~ch_en_q[1];
          ptr      <= sel;
          hold     <= HOLD_W'(1);
          state    <= GRANT;
        end

        GRANT: begin
          if (rel_req || forced_rot) begin
            out_gnt  <= '0;
            out_G1_n <= 1'b1;
            out_G2_n <= 1'b1;
            gap_cnt  <= GAP_W'(1);
            state    <= GAP;
          end else if (hold != HOLD_LIMIT) begin
            hold <= hold + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            if (pick_found) begin
              {out_A, out_B} <= pick_idx;
              ch_en_q        <= in_ch_en;
              state          <= SETUP;
            end else begin
              out_busy <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_als153_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_als153_rr_arbiter
//  Description : Self-checking bench. The arbiter drives a behavioural
//                SN54ALS153 dual 4:1 mux that has fixed, distinct C/D data
//                patterns.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_als153_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] ch  = 2'b00;
  logic       a, b, g1n, g2n, busy;
  logic [3:0] gnt;

  // Mux data: C0=1 C1=0 C2=1 C3=1, D0=0 D1=1 D2=0 D3=1.
  logic [3:0] c_data = 4'b1101;
  logic [3:0] d_data = 4'b1010;
  logic       y1, y2;

  int pass_cnt = 0;
  int total    = 0;
  int bbm_viol = 0;

  als153_rr_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(1)) dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .in_req   (req),
    .in_ch_en (ch),
    .out_A    (a),
    .out_B    (b),
    .out_G1_n (g1n),
    .out_G2_n (g2n),
    .out_gnt  (gnt),
    .out_busy (busy)
  );

  // SN54ALS153 model: a disabled section drives its output low.
  assign y1 = g1n ? 1'b0 : c_data[{a, b}];
  assign y2 = g2n ? 1'b0 : d_data[{a, b}];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [10:0] bundle();
    return {a, b, g1n, g2n, gnt, busy, y1, y2};
  endfunction

  // Break-before-make watcher. Each negedge follows exactly one posedge.
  logic [1:0] prev_ab;
  logic       prev_hi;
  bit         mon_valid = 0;
  always @(negedge clk) begin
    if (mon_valid && !rst && ({a, b} != prev_ab) && !(prev_hi && g1n && g2n)) begin
      bbm_viol++;
      $display("FAIL bbm: select moved %b->%b with an enable low (t=%0t)", prev_ab, {a, b}, $time);
    end
    prev_ab   = {a, b};
    prev_hi   = g1n & g2n;
    mon_valid = 1;
  end

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] ch;
    logic [1:0] ab;
    logic       g1n;
    logic       g2n;
    logic [3:0] gnt;
    logic       busy;
    logic       y1;
    logic       y2;
  } vec_t;

  vec_t vecs [19];

  initial begin : main
    int bad;
    int t, g, ph;
    logic [3:0] exp_gnt;
    logic [1:0] exp_ab;

    // Single-request sequences, one record per clock edge.
    // Fields: req, ch_en, {A,B}, G1_n, G2_n, gnt, busy, 1Y, 2Y.
    vecs[0]  = '{4'b0100, 2'b01, 2'b10, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 2'b01, 2'b10, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{4'b0100, 2'b01, 2'b10, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 2'b01, 2'b10, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 2'b01, 2'b10, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1000, 2'b11, 2'b11, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'b1000, 2'b11, 2'b11, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{4'b1000, 2'b00, 2'b11, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{4'b1000, 2'b00, 2'b11, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{4'b0000, 2'b00, 2'b11, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b0000, 2'b00, 2'b11, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0001, 2'b00, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'b0001, 2'b00, 2'b00, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'b0000, 2'b00, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'b0000, 2'b00, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'b0010, 2'b01, 2'b01, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{4'b0000, 2'b01, 2'b01, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{4'b0000, 2'b01, 2'b01, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{4'b0000, 2'b01, 2'b01, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};

    // Reset state.
    #1;
    rst = 1'b1;
    tick();
    check("reset_state", 32'(bundle()), 32'({2'b00, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;

    // Table-driven single-request sequences.
    for (int i = 0; i < 19; i++) begin
      req = vecs[i].req;
      ch  = vecs[i].ch;
      tick();
      check($sformatf("vec%0d", i), 32'(bundle()),
            32'({vecs[i].ab, vecs[i].g1n, vecs[i].g2n, vecs[i].gnt,
                 vecs[i].busy, vecs[i].y1, vecs[i].y2}));
    end

    // All four requesting: 8-cycle grants in order 0,1,2,3,0, with GAP+SETUP between them.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    ch  = 2'b11;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 1) begin
        exp_gnt = 4'b0000;
        exp_ab  = 2'd0;
      end else begin
        t  = c - 2;
        g  = t / 10;
        ph = t % 10;
        exp_gnt = (ph < 8) ? (4'b0001 << (g % 4)) : 4'b0000;
        exp_ab  = (ph == 9) ? 2'((g + 1) % 4) : 2'(g % 4);
      end
      check($sformatf("rr_all_c%0d", c), 32'({a, b, g1n, g2n, gnt}),
            32'({exp_ab, (exp_gnt == 0), (exp_gnt == 0), exp_gnt}));
    end

    // Reset taken in the middle of a grant.
    rst = 1'b1;
    tick();
    check("reset_mid_grant", 32'({a, b, g1n, g2n, gnt, busy}),
          32'({2'b00, 1'b1, 1'b1, 4'b0000, 1'b0}));
    rst = 1'b0;
    req = 4'b0000;
    tick();

    // Lone requester keeps the grant for 20 cycles. No forced rotate happens.
    req = 4'b0010;
    ch  = 2'b01;
    tick();
    tick();
    check("solo_first", 32'(gnt), 32'(4'b0010));
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (gnt != 4'b0010) bad++;
    end
    check("solo_hold_20", 32'(bad), 32'd0);
    req = 4'b0000;
    tick();
    check("solo_gap", 32'({g1n, g2n, gnt, busy}), 32'({1'b1, 1'b1, 4'b0000, 1'b1}));
    tick();
    check("solo_idle", 32'({gnt, busy}), 32'({4'b0000, 1'b0}));

    // req0 is granted and req3 arrives. req0 releases exactly at hold=8, which gives a single GAP.
    req = 4'b0001;
    tick();
    tick();
    check("sim_grant0", 32'(gnt), 32'(4'b0001));
    req = 4'b1001;
    bad = 0;
    for (int n = 2; n <= 8; n++) begin
      tick();
      if (gnt != 4'b0001) bad++;
    end
    check("sim_hold8", 32'(bad), 32'd0);
    req = 4'b1000;
    tick();
    check("sim_gap", 32'({a, b, g1n, g2n, gnt, busy}),
          32'({2'b00, 1'b1, 1'b1, 4'b0000, 1'b1}));
    tick();
    check("sim_setup3", 32'({a, b, g1n, g2n, gnt}), 32'({2'b11, 1'b1, 1'b1, 4'b0000}));
    tick();
    check("sim_grant3", 32'({a, b, g1n, g2n, gnt, y1}),
          32'({2'b11, 1'b0, 1'b1, 4'b1000, 1'b1}));
    req = 4'b0000;
    tick();
    tick();
    check("sim_idle", 32'(busy), 32'd0);

    check("bbm_violations", 32'(bbm_viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
